// File: rtl/riscv_dp_encode_imm_pkg.sv
// ============================================================================
// riscv_dp_encode_imm_pkg : immediate format codes and range helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_dp_encode_imm_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100
  } imm_fmt_e;

  localparam int unsigned FIFO_DEPTH  = 2;
  localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

  // True when imm[31:msb] are all equal, i.e. the value survives truncation to msb+1 bits.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] hi;
    hi = 32'($signed(imm) >>> msb);
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_dp_imm_pack.sv
// ============================================================================
// riscv_dp_imm_pack : packs immediate and register fields into an instruction
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_dp_imm_pack (
  input  logic [2:0]  src_i,
  input  logic [31:0] imm_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] instr_o,
  output logic        err_o
);
  import riscv_dp_encode_imm_pkg::*;

  always_comb begin
    instr_o = 32'h0000_0000;
    err_o   = 1'b1;
    case (src_i)
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err_o   = ~fits_signed(imm_i, 11);
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err_o   = ~fits_signed(imm_i, 11);
      end
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        err_o   = ~fits_signed(imm_i, 12) | imm_i[0];
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err_o   = ~fits_signed(imm_i, 20) | imm_i[0];
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        err_o   = |imm_i[11:0];
      end
      default: begin
        instr_o = 32'h0000_0000;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_dp_encode_imm.sv
// ============================================================================
// riscv_dp_encode_imm : instruction encoder with 2-entry output FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_dp_encode_imm (
  input  logic        iclk,
  input  logic        irst,
  input  logic        ivalid,
  output logic        oready,
  input  logic [2:0]  isrc,
  input  logic [31:0] iimm,
  input  logic [6:0]  iopcode,
  input  logic [4:0]  ird,
  input  logic [4:0]  irs1,
  input  logic [4:0]  irs2,
  input  logic [2:0]  ifunct3,
  output logic        ovalid,
  input  logic        iready,
  output logic [31:0] oinstr,
  output logic        oerr,
  output logic [7:0]  oerr_cnt
);
  import riscv_dp_encode_imm_pkg::*;

  logic [31:0]      pack_instr;
  logic             pack_err;
  logic [1:0][32:0] mem_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             accept;
  logic             pop;

  riscv_dp_imm_pack u_pack (
    .src_i    (isrc),
    .imm_i    (iimm),
    .opcode_i (iopcode),
    .rd_i     (ird),
    .rs1_i    (irs1),
    .rs2_i    (irs2),
    .funct3_i (ifunct3),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  // Handshake flags come only from registered occupancy, never from iready.
  assign oready = (count_q < 2'(FIFO_DEPTH));
  assign ovalid = (count_q != 2'd0);
  assign accept = ivalid & oready;
  assign pop    = ovalid & iready;

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    err_cnt_d = err_cnt_q;
    if (accept && pack_err && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      mem_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      err_cnt_q <= 8'd0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= {pack_err, pack_instr};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Stale entries stay hidden once the FIFO drains.
  assign oinstr   = ovalid ? mem_q[rd_ptr_q][31:0] : 32'h0000_0000;
  assign oerr     = ovalid ? mem_q[rd_ptr_q][32]   : 1'b0;
  assign oerr_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_dp_encode_imm.sv
// ============================================================================
// tb_riscv_dp_encode_imm : self-checking bench for riscv_dp_encode_imm
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_riscv_dp_encode_imm;

  logic        iclk = 1'b0;
  logic        irst;
  logic        ivalid;
  logic        oready;
  logic [2:0]  isrc;
  logic [31:0] iimm;
  logic [6:0]  iopcode;
  logic [4:0]  ird, irs1, irs2;
  logic [2:0]  ifunct3;
  logic        ovalid;
  logic        iready;
  logic [31:0] oinstr;
  logic        oerr;
  logic [7:0]  oerr_cnt;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;
  logic [32:0] q[$];

  always #5 iclk = ~iclk;

  riscv_dp_encode_imm dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .oready(oready),
    .isrc(isrc), .iimm(iimm), .iopcode(iopcode), .ird(ird),
    .irs1(irs1), .irs2(irs2), .ifunct3(ifunct3), .ovalid(ovalid),
    .iready(iready), .oinstr(oinstr), .oerr(oerr), .oerr_cnt(oerr_cnt)
  );

  // Reference encoder: legality from numeric range, fields placed by shifting.
  function automatic logic [32:0] ref_enc(input logic [2:0] src, input logic [31:0] imm,
                                          input logic [6:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3);
    longint      s;
    logic [31:0] w;
    logic        bad;
    s   = longint'($signed(imm));
    w   = 32'(opc);
    bad = 1'b0;
    case (src)
      3'd0: begin
        bad = (s < -2048) || (s > 2047);
        w |= ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
      end
      3'd1: begin
        bad = (s < -2048) || (s > 2047);
        w |= (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
           | (32'(f3) << 12) | ((imm & 32'h1F) << 7);
      end
      3'd2: begin
        bad = (s < -4096) || (s > 4095) || (s % 2 != 0);
        w |= (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
           | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
           | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      end
      3'd3: begin
        bad = (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1) || (s % 2 != 0);
        w |= (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
           | (32'(rd) << 7);
      end
      3'd4: begin
        bad = (s % 4096 != 0);
        w |= (imm & 32'hFFFF_F000) | (32'(rd) << 7);
      end
      default: begin
        bad = 1'b1;
        w   = 32'h0;
      end
    endcase
    return {bad, w};
  endfunction

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] opc,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3);
    isrc = src; iimm = imm; iopcode = opc; ird = rd; irs1 = rs1; irs2 = rs2; ifunct3 = f3;
  endtask

  task automatic rand_req();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0:       imm = $urandom;
      1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       imm = 32'($urandom_range(0, 4095)) << 12;
      default: imm = (32'($urandom_range(0, 4194303)) - 32'd2097152) & 32'hFFFF_FFFE;
    endcase
    set_req(3'($urandom_range(0, 7)), imm, 7'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), 3'($urandom));
  endtask

  // Model bookkeeping for an accepted request with the currently driven fields.
  task automatic model_accept();
    logic [32:0] e;
    e = ref_enc(isrc, iimm, iopcode, ird, irs1, irs2, ifunct3);
    q.push_back(e);
    if (e[32] && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic drive_one(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] opc,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3);
    set_req(src, imm, opc, rd, rs1, rs2, f3);
    ivalid = 1'b1;
    model_accept();
    void'(q.pop_front());
    step();
    ivalid = 1'b0;
  endtask

  task automatic do_reset();
    irst = 1'b1; ivalid = 1'b0; iready = 1'b1;
    step();
    irst = 1'b0;
    q.delete();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    irst = 1'b1; ivalid = 1'b0; iready = 1'b0;
    set_req(3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    step(); step();
    checks++;
    if (ovalid !== 1'b0 || oerr !== 1'b0 || oinstr !== 32'h0 || oerr_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: ovalid=%b oerr=%b oinstr=%h cnt=%0d, want 0/0/0/0",
               ovalid, oerr, oinstr, oerr_cnt);
    end
    irst = 1'b0;
    step();
    checks++;
    if (oready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: oready=%b, want 1", oready);
    end
    exp_cnt = 0;
  endtask

  task automatic test_directed();
    iready = 1'b1;
    drive_one(3'd0, 32'd5, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0);
    checks++;
    if (ovalid !== 1'b1 || oinstr !== 32'h00500093 || oerr !== 1'b0) begin
      errors++;
      $display("FAIL enc_I: ovalid=%b oinstr=%h oerr=%b, want 1 00500093 0", ovalid, oinstr, oerr);
    end
    drive_one(3'd1, 32'd8, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010);
    checks++;
    if (oinstr !== 32'h0020A423 || oerr !== 1'b0) begin
      errors++;
      $display("FAIL enc_S: oinstr=%h oerr=%b, want 0020a423 0", oinstr, oerr);
    end
    drive_one(3'd2, -32'sd4, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0);
    checks++;
    if (oinstr !== 32'hFE000EE3 || oerr !== 1'b0) begin
      errors++;
      $display("FAIL enc_B: oinstr=%h oerr=%b, want fe000ee3 0", oinstr, oerr);
    end
    drive_one(3'd3, 32'h800, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0);
    checks++;
    if (oinstr !== 32'h001000EF || oerr !== 1'b0) begin
      errors++;
      $display("FAIL enc_J: oinstr=%h oerr=%b, want 001000ef 0", oinstr, oerr);
    end
    drive_one(3'd4, 32'h12345000, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0);
    checks++;
    if (oinstr !== 32'h123452B7 || oerr !== 1'b0) begin
      errors++;
      $display("FAIL enc_U: oinstr=%h oerr=%b, want 123452b7 0", oinstr, oerr);
    end
    step();
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL drain_directed: ovalid=%b, want 0", ovalid);
    end
  endtask

  task automatic test_errors();
    logic [32:0] e;
    do_reset();
    drive_one(3'd0, 32'd2048, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0);
    checks++;
    if (oerr !== 1'b1 || oinstr !== 32'h80010093) begin
      errors++;
      $display("FAIL err_I_range: oerr=%b oinstr=%h, want 1 80010093", oerr, oinstr);
    end
    e = ref_enc(3'd2, 32'd6, 7'b1100011, 5'd0, 5'd3, 5'd4, 3'd1);
    drive_one(3'd2, 32'd6, 7'b1100011, 5'd0, 5'd3, 5'd4, 3'd1);
    checks++;
    if (oerr !== 1'b0 || oinstr !== e[31:0]) begin
      errors++;
      $display("FAIL ok_B_small: oerr=%b oinstr=%h, want 0 %h", oerr, oinstr, e[31:0]);
    end
    drive_one(3'd4, 32'h1001, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0);
    checks++;
    if (oerr !== 1'b1 || oinstr !== 32'h000012B7) begin
      errors++;
      $display("FAIL err_U_low: oerr=%b oinstr=%h, want 1 000012b7", oerr, oinstr);
    end
    drive_one(3'd7, 32'd4, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7);
    checks++;
    if (oerr !== 1'b1 || oinstr !== 32'h0) begin
      errors++;
      $display("FAIL err_illegal_src: oerr=%b oinstr=%h, want 1 00000000", oerr, oinstr);
    end
    checks++;
    if (oerr_cnt !== 8'd3) begin
      errors++;
      $display("FAIL err_count: oerr_cnt=%0d, want 3", oerr_cnt);
    end
    step();
  endtask

  task automatic test_backpressure();
    int sent = 0, popped = 0;
    bit saw_both = 0;
    bit acc, pp;
    do_reset();
    iready = 1'b0;
    rand_req();
    for (int c = 0; c < 10; c++) begin
      iready = (c >= 3);
      ivalid = (sent < 3);
      #1;
      checks++;
      if (ovalid !== (q.size() != 0) || oready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL bp_flags c=%0d: ovalid=%b oready=%b, want %b %b",
                 c, ovalid, oready, q.size() != 0, q.size() < 2);
      end
      if (c == 2) begin
        checks++;
        if (oready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_drop: oready=%b, want 0", oready);
        end
      end
      acc = ivalid && (q.size() < 2);
      pp  = iready && (q.size() != 0);
      if (q.size() != 0) begin
        checks++;
        if (oinstr !== q[0][31:0] || oerr !== q[0][32]) begin
          errors++;
          $display("FAIL bp_word c=%0d: oinstr=%h oerr=%b, want %h %b",
                   c, oinstr, oerr, q[0][31:0], q[0][32]);
        end
      end
      if (pp) begin void'(q.pop_front()); popped++; end
      if (acc) begin model_accept(); sent++; end
      if (acc && pp) saw_both = 1;
      step();
      if (acc) rand_req();
    end
    ivalid = 1'b0;
    checks++;
    if (sent != 3 || popped != 3 || saw_both != 1 || ovalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_totals: sent=%0d popped=%0d both=%0d ovalid=%b, want 3 3 1 0",
               sent, popped, saw_both, ovalid);
    end
  endtask

  task automatic test_random();
    bit acc, pp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_req();
      ivalid = ($urandom_range(0, 2) != 0);
      iready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (ovalid !== (q.size() != 0) || oready !== (q.size() < 2) || oerr_cnt !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL rnd_flags c=%0d: ovalid=%b oready=%b cnt=%0d, want %b %b %0d",
                 c, ovalid, oready, oerr_cnt, q.size() != 0, q.size() < 2, exp_cnt);
      end
      if (q.size() != 0) begin
        checks++;
        if (oinstr !== q[0][31:0] || oerr !== q[0][32]) begin
          errors++;
          $display("FAIL rnd_word c=%0d: oinstr=%h oerr=%b, want %h %b",
                   c, oinstr, oerr, q[0][31:0], q[0][32]);
        end
      end
      acc = ivalid && (q.size() < 2);
      pp  = iready && (q.size() != 0);
      if (pp) void'(q.pop_front());
      if (acc) model_accept();
      step();
    end
    ivalid = 1'b0;
    iready = 1'b1;
    step(); step();
    checks++;
    if (ovalid !== 1'b0 || oerr_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL rnd_drain: ovalid=%b cnt=%0d, want 0 %0d", ovalid, oerr_cnt, exp_cnt);
    end
    q.delete();
  endtask

  task automatic test_saturate();
    do_reset();
    set_req(3'd7, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    ivalid = 1'b1;
    iready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (q.size() < 2) model_accept();
      if (q.size() != 0 && c > 0) void'(q.pop_front());
      step();
    end
    ivalid = 1'b0;
    checks++;
    if (oerr_cnt !== 8'd255 || exp_cnt != 255) begin
      errors++;
      $display("FAIL err_cnt_saturate: oerr_cnt=%0d, want 255", oerr_cnt);
    end
    step(); step();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    iready = 1'b0;
    drive_one(3'd7, 32'd0, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0);
    drive_one(3'd0, 32'd9999, 7'h13, 5'd2, 5'd2, 5'd2, 3'd0);
    checks++;
    if (ovalid !== 1'b1 || oready !== 1'b0 || oerr_cnt !== 8'd2) begin
      errors++;
      $display("FAIL mid_fill: ovalid=%b oready=%b cnt=%0d, want 1 0 2", ovalid, oready, oerr_cnt);
    end
    irst = 1'b1;
    ivalid = 1'b1;
    iready = 1'b1;
    step();
    checks++;
    if (ovalid !== 1'b0 || oerr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: ovalid=%b cnt=%0d, want 0 0", ovalid, oerr_cnt);
    end
    irst = 1'b0;
    ivalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (ovalid !== 1'b0 || oready !== 1'b1) begin
        errors++;
        $display("FAIL mid_discard c=%0d: ovalid=%b oready=%b, want 0 1", c, ovalid, oready);
      end
      step();
    end
  endtask

  initial begin
    irst = 1'b1; ivalid = 1'b0; iready = 1'b0;
    set_req(3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_random();
    test_saturate();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
